// File: rtl/clock_meter_scheduler_if.sv
// Software-facing control, limit and result-read bundle of the clock meter scheduler.
// The scheduler takes the slave side; the controlling agent takes the master side.
interface clock_meter_scheduler_if #(
  parameter int NUM_CH = 8,
  parameter int VAL_W  = 32
);
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              start_i;
  logic              cont_i;
  logic [NUM_CH-1:0] ch_en_i;
  logic [VAL_W-1:0]  lim_lo_i;
  logic [VAL_W-1:0]  lim_hi_i;
  logic              busy_o;
  logic              scan_done_o;
  logic [SEL_W-1:0]  rd_ch_i;
  logic [VAL_W-1:0]  rd_val_o;
  logic [NUM_CH-1:0] fault_o;
  logic [NUM_CH-1:0] valid_o;

  modport slave (
    input  start_i, cont_i, ch_en_i, lim_lo_i, lim_hi_i, rd_ch_i,
    output busy_o, scan_done_o, rd_val_o, fault_o, valid_o
  );

  modport master (
    output start_i, cont_i, ch_en_i, lim_lo_i, lim_hi_i, rd_ch_i,
    input  busy_o, scan_done_o, rd_val_o, fault_o, valid_o
  );
endinterface

// File: rtl/clock_meter_scheduler.sv
// Steps one shared clock meter across the enabled mux channels: switch mux under meter
// reset, wait one gate window plus output latency, capture and limit-check the result.
module clock_meter_scheduler #(
  parameter int NUM_CH        = 8,
  parameter int WINDOW_CYCLES = 10000000,
  parameter int CAPTURE_LAT   = 3,
  parameter int RST_CYCLES    = 16,
  parameter int VAL_W         = 32,
  localparam int SEL_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic               clk_i,
  input  logic               a_rst_n_i,
  clock_meter_scheduler_if.slave ctl,
  input  logic [VAL_W-1:0]   meter_val_i,
  output logic [SEL_W-1:0]   mux_sel_o,
  output logic               meter_rst_n_o
);

  localparam int GATE_CYCLES = WINDOW_CYCLES + CAPTURE_LAT;
  localparam int CNT_MAX     = (GATE_CYCLES > RST_CYCLES) ? GATE_CYCLES : RST_CYCLES;
  localparam int CNT_W       = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] GATE_LAST = CNT_W'(GATE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    SWITCH,
    GATE,
    CAPTURE,
    NEXT
  } state_t;

  state_t            state_q;
  logic [NUM_CH-1:0] mask_q;
  logic [SEL_W-1:0]  ch_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [SEL_W-1:0]  mux_sel_q;
  logic              meter_rst_n_q;
  logic              scan_done_q;

  logic [VAL_W-1:0]  val_q [NUM_CH];
  logic [NUM_CH-1:0] valid_q;
  logic [NUM_CH-1:0] fault_q;

  logic [NUM_CH-1:0] above_d;
  logic [NUM_CH-1:0] cap_hit_d;
  logic              has_next_d;
  logic [SEL_W-1:0]  next_ch_d;
  logic [SEL_W-1:0]  first_ch_d;
  logic              fault_d;

  function automatic logic [SEL_W-1:0] lowest_idx(input logic [NUM_CH-1:0] m);
    lowest_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (m[i]) lowest_idx = SEL_W'(i);
    end
  endfunction

  // Enabled channels strictly above the current one decide whether the pass continues.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
    assign above_d[gi]   = mask_q[gi] & (gi > int'(ch_q));
    assign cap_hit_d[gi] = (state_q == CAPTURE) && (ch_q == SEL_W'(gi));
  end

  assign has_next_d = |above_d;
  assign next_ch_d  = lowest_idx(above_d);
  assign first_ch_d = lowest_idx(ctl.ch_en_i);
  assign fault_d    = (meter_val_i < ctl.lim_lo_i) | (meter_val_i > ctl.lim_hi_i);

  always_ff @(posedge clk_i or negedge a_rst_n_i) begin
    if (!a_rst_n_i) begin
      state_q       <= IDLE;
      mask_q        <= '0;
      ch_q          <= '0;
      cnt_q         <= '0;
      mux_sel_q     <= '0;
      meter_rst_n_q <= 1'b0;
      scan_done_q   <= 1'b0;
    end else begin
      scan_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          meter_rst_n_q <= 1'b1;
          if (ctl.start_i) begin
            if (|ctl.ch_en_i) begin
              mask_q        <= ctl.ch_en_i;
              ch_q          <= first_ch_d;
              mux_sel_q     <= first_ch_d;
              meter_rst_n_q <= 1'b0;
              cnt_q         <= '0;
              state_q       <= SWITCH;
            end else begin
              scan_done_q <= 1'b1;
            end
          end
        end
        SWITCH: begin
          if (cnt_q == RST_LAST) begin
            cnt_q         <= '0;
            meter_rst_n_q <= 1'b1;
            state_q       <= GATE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        GATE: begin
          if (cnt_q == GATE_LAST) begin
            cnt_q   <= '0;
            state_q <= CAPTURE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        CAPTURE: begin
          // Pulse lands in NEXT, one cycle after the last channel's capture.
          scan_done_q <= ~has_next_d;
          state_q     <= NEXT;
        end
        NEXT: begin
          if (has_next_d) begin
            ch_q          <= next_ch_d;
            mux_sel_q     <= next_ch_d;
            meter_rst_n_q <= 1'b0;
            state_q       <= SWITCH;
          end else if (ctl.cont_i && (|ctl.ch_en_i)) begin
            mask_q        <= ctl.ch_en_i;
            ch_q          <= first_ch_d;
            mux_sel_q     <= first_ch_d;
            meter_rst_n_q <= 1'b0;
            state_q       <= SWITCH;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge a_rst_n_i) begin
    if (!a_rst_n_i) begin
      for (int i = 0; i < NUM_CH; i++) val_q[i] <= '0;
      valid_q <= '0;
      fault_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (cap_hit_d[i]) begin
          val_q[i]   <= meter_val_i;
          valid_q[i] <= 1'b1;
          fault_q[i] <= fault_d;
        end
      end
    end
  end

  assign mux_sel_o       = mux_sel_q;
  assign meter_rst_n_o   = meter_rst_n_q;
  assign ctl.busy_o      = (state_q != IDLE);
  assign ctl.scan_done_o = scan_done_q;
  assign ctl.fault_o     = fault_q;
  assign ctl.valid_o     = valid_q;
  assign ctl.rd_val_o    = (int'(ctl.rd_ch_i) < NUM_CH) ? val_q[ctl.rd_ch_i] : '0;

endmodule

// File: tb/tb_clock_meter_scheduler.sv
// Directed bench: table of scan passes with hand-computed results, plus continuous-mode
// and mid-pass reset sequences, against a meter model that outputs 10*ch+5 per window.
module tb_clock_meter_scheduler;
  localparam int NUM_CH = 4;
  localparam int WIN    = 100;
  localparam int LAT    = 3;
  localparam int RSTC   = 4;

  logic       clk = 1'b0;
  logic       a_rst_n = 1'b0;
  logic [1:0] mux_sel;
  logic       meter_rst_n;
  logic [31:0] meter_val = '0;
  int         mcnt = 0;

  int checks = 0;
  int errors = 0;

  clock_meter_scheduler_if #(.NUM_CH(NUM_CH), .VAL_W(32)) ifc ();

  clock_meter_scheduler #(
    .NUM_CH(NUM_CH), .WINDOW_CYCLES(WIN), .CAPTURE_LAT(LAT),
    .RST_CYCLES(RSTC), .VAL_W(32)
  ) dut (
    .clk_i(clk),
    .a_rst_n_i(a_rst_n),
    .ctl(ifc),
    .meter_val_i(meter_val),
    .mux_sel_o(mux_sel),
    .meter_rst_n_o(meter_rst_n)
  );

  always #5 clk = ~clk;

  // Meter model: result valid LAT cycles after a WIN-cycle window that starts on release.
  always @(posedge clk) begin
    if (!meter_rst_n) begin
      mcnt      <= 0;
      meter_val <= '0;
    end else begin
      mcnt <= mcnt + 1;
      if (mcnt == WIN + LAT - 1) meter_val <= 32'(10 * int'(mux_sel) + 5);
    end
  end

  typedef struct {
    logic [3:0]  en;
    logic [31:0] lo;
    logic [31:0] hi;
    bit          rep;
    int          done;
    int          n;
    logic [15:0] seq;
    logic [3:0]  valid;
    logic [3:0]  fault;
    logic [31:0] v0, v1, v2, v3;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_pass(input logic [3:0] en, input logic [31:0] lo, input logic [31:0] hi,
                          input bit rep, output int done_cyc, output int nsel,
                          output logic [15:0] seq, output int low_cnt, output bit busy_seen);
    bit prev_rst;
    int cyc;
    done_cyc = -1; nsel = 0; seq = '0; low_cnt = 0; busy_seen = 0;
    @(posedge clk); #1;
    ifc.ch_en_i = en; ifc.lim_lo_i = lo; ifc.lim_hi_i = hi; ifc.start_i = 1'b1;
    prev_rst = meter_rst_n;
    cyc = 0;
    while (done_cyc < 0 && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
      ifc.start_i = rep && (cyc == 50);
      if (rep && cyc == 50) ifc.ch_en_i = 4'hF;
      if (ifc.busy_o) busy_seen = 1;
      if (!meter_rst_n && ifc.busy_o) begin
        low_cnt++;
        if (prev_rst) begin
          if (nsel < 4) seq[nsel*4 +: 4] = {2'b00, mux_sel};
          nsel++;
        end
      end
      prev_rst = meter_rst_n;
      if (ifc.scan_done_o) done_cyc = cyc;
    end
    ifc.start_i = 1'b0;
  endtask

  task automatic apply_row(input int r);
    int done_cyc, nsel, low_cnt;
    logic [15:0] seq;
    bit busy_seen;
    logic [31:0] ev;
    run_pass(vecs[r].en, vecs[r].lo, vecs[r].hi, vecs[r].rep, done_cyc, nsel, seq, low_cnt, busy_seen);
    chk($sformatf("row%0d done_cycle", r), 64'(done_cyc), 64'(vecs[r].done));
    chk($sformatf("row%0d sel_count", r), 64'(nsel), 64'(vecs[r].n));
    chk($sformatf("row%0d sel_seq", r), 64'(seq), 64'(vecs[r].seq));
    chk($sformatf("row%0d rst_low_cycles", r), 64'(low_cnt), 64'(RSTC * vecs[r].n));
    chk($sformatf("row%0d busy_seen", r), 64'(busy_seen), 64'(vecs[r].n != 0));
    chk($sformatf("row%0d valid", r), 64'(ifc.valid_o), 64'(vecs[r].valid));
    chk($sformatf("row%0d fault", r), 64'(ifc.fault_o), 64'(vecs[r].fault));
    for (int c = 0; c < 4; c++) begin
      ifc.rd_ch_i = 2'(c);
      #1;
      ev = (c == 0) ? vecs[r].v0 : (c == 1) ? vecs[r].v1 : (c == 2) ? vecs[r].v2 : vecs[r].v3;
      chk($sformatf("row%0d rd_val_ch%0d", r, c), 64'(ifc.rd_val_o), 64'(ev));
    end
    @(posedge clk); #1;
    chk($sformatf("row%0d busy_after", r), 64'(ifc.busy_o), 64'(0));
    $display("row %0d: en=%b done=%0d sel=%h valid=%b fault=%b", r, vecs[r].en, done_cyc, seq,
             ifc.valid_o, ifc.fault_o);
  endtask

  initial begin
    int cyc, pulses, p1, p2;
    vecs[0] = '{4'b1011, 32'd0,  32'hFFFF_FFFF, 1'b0, 327, 3, 16'h0310, 4'b1011, 4'b0000, 32'd5, 32'd15, 32'd0,  32'd35};
    vecs[1] = '{4'b1111, 32'd10, 32'd30,        1'b0, 436, 4, 16'h3210, 4'b1111, 4'b1001, 32'd5, 32'd15, 32'd25, 32'd35};
    vecs[2] = '{4'b0000, 32'd0,  32'd0,         1'b0, 1,   0, 16'h0000, 4'b1111, 4'b1001, 32'd5, 32'd15, 32'd25, 32'd35};
    vecs[3] = '{4'b0100, 32'd26, 32'd40,        1'b0, 109, 1, 16'h0002, 4'b1111, 4'b1101, 32'd5, 32'd15, 32'd25, 32'd35};
    vecs[4] = '{4'b0001, 32'd5,  32'd5,         1'b1, 109, 1, 16'h0000, 4'b1111, 4'b1100, 32'd5, 32'd15, 32'd25, 32'd35};
    vecs[5] = '{4'b1000, 32'd35, 32'd35,        1'b0, 109, 1, 16'h0003, 4'b1111, 4'b0100, 32'd5, 32'd15, 32'd25, 32'd35};
    vecs[6] = '{4'b0011, 32'd0,  32'hFFFF_FFFF, 1'b0, 218, 2, 16'h0010, 4'b0011, 4'b0000, 32'd5, 32'd15, 32'd0,  32'd0};

    ifc.start_i = 1'b0; ifc.cont_i = 1'b0; ifc.ch_en_i = '0;
    ifc.lim_lo_i = '0; ifc.lim_hi_i = '1; ifc.rd_ch_i = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst mux_sel", 64'(mux_sel), 64'(0));
    chk("rst meter_rst_n", 64'(meter_rst_n), 64'(0));
    chk("rst busy", 64'(ifc.busy_o), 64'(0));
    chk("rst scan_done", 64'(ifc.scan_done_o), 64'(0));
    chk("rst fault", 64'(ifc.fault_o), 64'(0));
    chk("rst valid", 64'(ifc.valid_o), 64'(0));
    chk("rst rd_val", 64'(ifc.rd_val_o), 64'(0));
    @(negedge clk); a_rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle meter_rst_n", 64'(meter_rst_n), 64'(1));
    $display("reset: mux_sel=%0d meter_rst_n=%b", mux_sel, meter_rst_n);

    for (int r = 0; r < 6; r++) apply_row(r);

    // Continuous mode, dropped mid second pass
    ifc.ch_en_i = 4'b0011; ifc.lim_lo_i = '0; ifc.lim_hi_i = '1; ifc.cont_i = 1'b1;
    @(posedge clk); #1;
    ifc.start_i = 1'b1;
    cyc = 0; pulses = 0; p1 = -1; p2 = -1;
    while (cyc < 800) begin
      @(posedge clk); #1;
      cyc++;
      ifc.start_i = 1'b0;
      if (ifc.scan_done_o) begin
        pulses++;
        if (pulses == 1) p1 = cyc;
        else if (pulses == 2) p2 = cyc;
      end
      if (p1 > 0 && cyc == p1 + 10) ifc.cont_i = 1'b0;
    end
    chk("cont pulses", 64'(pulses), 64'(2));
    chk("cont first_done", 64'(p1), 64'(218));
    chk("cont second_done", 64'(p2), 64'(436));
    chk("cont busy_end", 64'(ifc.busy_o), 64'(0));
    $display("cont: pulses=%0d at %0d,%0d busy=%b", pulses, p1, p2, ifc.busy_o);

    // Asynchronous reset during channel 1 gate
    ifc.ch_en_i = 4'b0011;
    @(posedge clk); #1;
    ifc.start_i = 1'b1;
    @(posedge clk); #1;
    ifc.start_i = 1'b0;
    for (int k = 2; k <= 133; k++) @(posedge clk);
    #1;
    chk("pre_rst mux_sel", 64'(mux_sel), 64'(1));
    chk("pre_rst meter_rst_n", 64'(meter_rst_n), 64'(1));
    chk("pre_rst busy", 64'(ifc.busy_o), 64'(1));
    chk("pre_rst valid", 64'(ifc.valid_o), 64'(4'b1111));
    #2 a_rst_n = 1'b0;
    ifc.rd_ch_i = 2'd0;
    #1;
    chk("mid_rst busy", 64'(ifc.busy_o), 64'(0));
    chk("mid_rst mux_sel", 64'(mux_sel), 64'(0));
    chk("mid_rst meter_rst_n", 64'(meter_rst_n), 64'(0));
    chk("mid_rst valid", 64'(ifc.valid_o), 64'(0));
    chk("mid_rst fault", 64'(ifc.fault_o), 64'(0));
    chk("mid_rst scan_done", 64'(ifc.scan_done_o), 64'(0));
    chk("mid_rst rd_val", 64'(ifc.rd_val_o), 64'(0));
    $display("mid-pass reset: busy=%b valid=%b mux_sel=%0d", ifc.busy_o, ifc.valid_o, mux_sel);
    repeat (2) @(posedge clk);
    #2 a_rst_n = 1'b1;
    apply_row(6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
